// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution stage: condition codes, flag
// bit positions and the flag-shadow FSM states.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SAVED = 1'b1
  } shadow_state_e;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARMv4 condition evaluator: {N,Z,C,V} + Cond -> pass.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[N_IDX];
  assign w_z = i_flags[Z_IDX];
  assign w_c = i_flags[C_IDX];
  assign w_v = i_flags[V_IDX];

  // Decode the condition field against the current flags
  always_comb begin
    o_cond_ex = 1'b0;
    case (cond_e'(i_cond))
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = (w_n == w_v);
      COND_LT: o_cond_ex = (w_n != w_v);
      COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ex = w_z | (w_n != w_v);
      COND_AL: o_cond_ex = 1'b1;
      COND_NV: o_cond_ex = 1'b0;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Conditional-execution stage: architectural flag register, write-enable gating
// and an optional flag shadow (save/restore) built when FLAG_SHADOW_EN is defined.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int          COND_W   = 4,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              stall,
  input  logic [COND_W-1:0] Cond,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  input  logic [3:0]        ALUFlags,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              CondEx,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [3:0]        Flags,
  output logic              shadow_ack
);

  logic [3:0] r_flags;
  logic [3:0] w_flags_nxt;
  logic [3:0] w_shadow;
  logic       w_restore;
  logic       w_cond_ex;
  logic       w_go;

  cond_check u_cond_check (
    .i_cond    (Cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  assign w_go     = valid & ~stall & w_cond_ex;
  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_go;
  assign RegWrite = RegW & w_go & ~NoWrite;
  assign MemWrite = MemW & w_go;
  assign Flags    = r_flags;

  // Next flag value: independent N/Z and C/V halves; a restore overrides both
  always_comb begin
    w_flags_nxt = r_flags;
    if (w_restore) begin
      w_flags_nxt = w_shadow;
    end else begin
      if (w_go && FlagW[1]) begin
        w_flags_nxt[N_IDX:Z_IDX] = ALUFlags[N_IDX:Z_IDX];
      end else begin
        w_flags_nxt[N_IDX:Z_IDX] = r_flags[N_IDX:Z_IDX];
      end
      if (w_go && FlagW[0]) begin
        w_flags_nxt[C_IDX:V_IDX] = ALUFlags[C_IDX:V_IDX];
      end else begin
        w_flags_nxt[C_IDX:V_IDX] = r_flags[C_IDX:V_IDX];
      end
    end
  end

  // Architectural flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= FLAG_RST;
    end else begin
      r_flags <= w_flags_nxt;
    end
  end

`ifdef FLAG_SHADOW_EN
  shadow_state_e r_state;
  logic [3:0]    r_shadow;
  logic          r_shadow_ack;

  assign w_restore  = (r_state == SAVED) & restore_req & ~stall;
  assign w_shadow   = r_shadow;
  assign shadow_ack = r_shadow_ack;

  // Save/restore FSM; the ack pulse is registered alongside the transition
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shadow     <= 4'b0000;
      r_shadow_ack <= 1'b0;
    end else if (stall) begin
      r_shadow_ack <= 1'b0;
    end else begin
      r_shadow_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (save_req) begin
            r_shadow     <= r_flags;
            r_state      <= SAVED;
            r_shadow_ack <= 1'b1;
          end
        end
        SAVED: begin
          if (restore_req) begin
            r_state      <= IDLE;
            r_shadow_ack <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  logic w_unused_shadow_req;

  assign w_unused_shadow_req = save_req ^ restore_req;
  assign w_restore           = 1'b0;
  assign w_shadow            = 4'b0000;
  assign shadow_ack          = 1'b0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed, table-driven bench for cond_flag_unit; the shadow sequence is
// exercised in whichever form FLAG_SHADOW_EN selects.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset, valid, stall;
  logic [3:0] Cond;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic [3:0] ALUFlags;
  logic       save_req, restore_req;
  logic       CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;
  logic       shadow_ack;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       valid;
    logic       stall;
    logic [3:0] cond;
    logic [1:0] flagw;
    logic       pcs, regw, memw, nowrite;
    logic [3:0] alu;
    logic [3:0] exp_en;    // {CondEx, PCSrc, RegWrite, MemWrite}
    logic [3:0] exp_flags; // Flags after the clock edge
  } vec_t;

  vec_t vecs[$];

  cond_flag_unit #(.COND_W(4), .FLAG_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .valid(valid), .stall(stall), .Cond(Cond),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .ALUFlags(ALUFlags), .save_req(save_req), .restore_req(restore_req),
    .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .shadow_ack(shadow_ack)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic s, input logic [3:0] c,
                              input logic [1:0] fw, input logic p, input logic r,
                              input logic m, input logic nw, input logic [3:0] a,
                              input logic [3:0] en, input logic [3:0] fl);
    vec_t t;
    t.valid = v; t.stall = s; t.cond = c; t.flagw = fw; t.pcs = p; t.regw = r;
    t.memw = m; t.nowrite = nw; t.alu = a; t.exp_en = en; t.exp_flags = fl;
    return t;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] c, input logic [1:0] fw,
                       input logic p, input logic r, input logic m, input logic nw,
                       input logic [3:0] a);
    valid = v; stall = s; Cond = c; FlagW = fw; PCS = p; RegW = r; MemW = m;
    NoWrite = nw; ALUFlags = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    //           v     s     cond     fw     pcs   regw  memw  nw    alu      en       flags
    vecs.push_back(mk(1'b1, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b1010, 4'b0100));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'b0100));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0100));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1110, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1100, 4'b0111));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b0111));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1001, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b1001, 4'b1000));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1000));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1011, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'b1000));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 4'b1000, 4'b1000));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 4'b0000, 4'b1000));
    vecs.push_back(mk(1'b0, 1'b0, 4'b1110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 4'b1000, 4'b1000));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b1010, 4'b0100));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0101, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1000, 4'b0111));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0111));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0011, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0111));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0111));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0111));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0111));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1101, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b1000, 4'b0001));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1101, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1000, 4'b1001));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b1001));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'b1001));

    // Reset state
    tick(); tick();
    check("reset_flags", Flags, 4'b0000);
    check("reset_ack", {3'b000, shadow_ack}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Table: combinational enables before the edge, flags after it
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].stall, vecs[i].cond, vecs[i].flagw, vecs[i].pcs,
            vecs[i].regw, vecs[i].memw, vecs[i].nowrite, vecs[i].alu);
      #1;
      check($sformatf("v%0d_en", i), {CondEx, PCSrc, RegWrite, MemWrite}, vecs[i].exp_en);
      tick();
      check($sformatf("v%0d_flags", i), Flags, vecs[i].exp_flags);
    end

    // Reset wins over a same-cycle flag write
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick();
    check("reset_wins", Flags, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Shadow sequence: set Flags=0110, save, overwrite with 1001, restore with a write
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
    tick();
    check("sh_pre_flags", Flags, 4'b0110);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    save_req = 1'b1;
    tick();
`ifdef FLAG_SHADOW_EN
    check("sh_save_ack", {3'b000, shadow_ack}, 4'b0001);
`else
    check("sh_save_ack", {3'b000, shadow_ack}, 4'b0000);
`endif
    @(negedge clk);
    tick();
    check("sh_save_again_ack", {3'b000, shadow_ack}, 4'b0000);
    @(negedge clk);
    save_req = 1'b0;
    drive(1'b1, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001);
    tick();
    check("sh_overwrite", Flags, 4'b1001);
    check("sh_ack_low", {3'b000, shadow_ack}, 4'b0000);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    restore_req = 1'b1;
    tick();
`ifdef FLAG_SHADOW_EN
    check("sh_restore_flags", Flags, 4'b0110);
    check("sh_restore_ack", {3'b000, shadow_ack}, 4'b0001);
`else
    check("sh_restore_flags", Flags, 4'b1111);
    check("sh_restore_ack", {3'b000, shadow_ack}, 4'b0000);
`endif
    // Restore while IDLE is ignored
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
    tick();
    check("sh_idle_restore_flags", Flags, 4'b0011);
    check("sh_idle_restore_ack", {3'b000, shadow_ack}, 4'b0000);
    @(negedge clk);
    restore_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
